// File: rtl/timer_prescaler1.sv
`timescale 1ns/1ps
// timer_prescaler1
//
// Clock-select and prescaler stage for the 16-bit Timer/Counter1 core.
// Holds the CS1[2:0] field of TCCR1B and runs a shared, free-running 10-bit
// prescaler. From these it produces count_tick, a registered one-cycle count
// enable at sysClock/1, /8, /64, /256, /1024, or on a synchronised edge of
// the external T1 pin. A PSR10 write through SFIOR clears the prescaler.
//
// Ports
//   sysClock             in   1  system clock, rising-edge active
//   reset                in   1  asynchronous, active-high reset
//   TCCR1B_input         in   8  TCCR1B write data, only [2:0] (CS12:CS10) used
//   TCCR1B_write_enable  in   1  latches TCCR1B_input[2:0] into clock_select
//   SFIOR_input          in   8  SFIOR write data, bit 0 = PSR10
//   SFIOR_write_enable   in   1  qualifies SFIOR_input
//   T1_pin               in   1  external count pin, asynchronous to sysClock
//   count_tick           out  1  registered count enable, one cycle per event
//   clock_select         out  3  currently latched CS1[2:0]
//   prescale_count       out 10  current prescaler value (debug)
//   timer_running        out  1  high when clock_select != 000
//
// There is no valid/ready handshake on this block: writes are single-cycle
// strobes that always take effect at the edge where they are sampled, and
// count_tick is a fire-and-forget enable with no back-pressure.
module timer_prescaler1 (
  input  logic       sysClock,
  input  logic       reset,
  input  logic [7:0] TCCR1B_input,
  input  logic       TCCR1B_write_enable,
  input  logic [7:0] SFIOR_input,
  input  logic       SFIOR_write_enable,
  input  logic       T1_pin,
  output logic       count_tick,
  output logic [2:0] clock_select,
  output logic [9:0] prescale_count,
  output logic       timer_running
);

  typedef enum logic [2:0] {
    CS_STOP     = 3'b000,
    CS_DIV1     = 3'b001,
    CS_DIV8     = 3'b010,
    CS_DIV64    = 3'b011,
    CS_DIV256   = 3'b100,
    CS_DIV1024  = 3'b101,
    CS_T1_FALL  = 3'b110,
    CS_T1_RISE  = 3'b111
  } cs_mode_e;

  cs_mode_e   cs_q;
  logic [9:0] prescaler;
  logic       t1_sync1;
  logic       t1_sync2;
  logic       t1_hist;
  logic [1:0] settle_cnt;

  logic       psr10;
  logic       edge_armed;
  logic       t1_rise;
  logic       t1_fall;
  logic       tick_next;

  // PSR10 is a strobe; it is never stored.
  assign psr10 = SFIOR_write_enable & SFIOR_input[0];

  // Edge detection stays masked until the settle counter saturates, so a T1
  // level already present when reset releases does not look like an edge
  // while the synchroniser and history flops fill up.
  assign edge_armed = (settle_cnt == 2'd3);
  assign t1_rise    = edge_armed &  t1_sync2 & ~t1_hist;
  assign t1_fall    = edge_armed & ~t1_sync2 &  t1_hist;

  always_comb begin
    tick_next = 1'b0;
    case (cs_q)
      CS_STOP:    tick_next = 1'b0;
      CS_DIV1:    tick_next = 1'b1;
      CS_DIV8:    tick_next = (prescaler[2:0] == 3'h7)   & ~psr10;
      CS_DIV64:   tick_next = (prescaler[5:0] == 6'h3f)  & ~psr10;
      CS_DIV256:  tick_next = (prescaler[7:0] == 8'hff)  & ~psr10;
      CS_DIV1024: tick_next = (prescaler     == 10'h3ff) & ~psr10;
      CS_T1_FALL: tick_next = t1_fall;
      CS_T1_RISE: tick_next = t1_rise;
      default:    tick_next = 1'b0;
    endcase
  end

  // Clock-select register. The tick decision above uses the value held
  // before this edge, so a new mode governs ticks from the following edge.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      cs_q <= CS_STOP;
    end else if (TCCR1B_write_enable) begin
      cs_q <= cs_mode_e'(TCCR1B_input[2:0]);
    end
  end

  // Free-running prescaler; not disturbed by clock-select changes.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      prescaler <= 10'd0;
    end else if (psr10) begin
      prescaler <= 10'd0;
    end else begin
      prescaler <= prescaler + 10'd1;
    end
  end

  // T1 path runs in every mode so that switching into an external mode
  // sees an up-to-date history and produces no spurious tick.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      t1_sync1   <= 1'b0;
      t1_sync2   <= 1'b0;
      t1_hist    <= 1'b0;
      settle_cnt <= 2'd0;
    end else begin
      t1_sync1 <= T1_pin;
      t1_sync2 <= t1_sync1;
      t1_hist  <= t1_sync2;
      if (settle_cnt != 2'd3) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      count_tick <= 1'b0;
    end else begin
      count_tick <= tick_next;
    end
  end

  assign clock_select   = cs_q;
  assign prescale_count = prescaler;
  assign timer_running  = (cs_q != CS_STOP);

endmodule

// File: tb/tb_timer_prescaler1.sv
`timescale 1ns/1ps
module tb_timer_prescaler1;

  logic       clk;
  logic       rst;
  logic [7:0] tccr1b_in;
  logic       tccr1b_we;
  logic [7:0] sfior_in;
  logic       sfior_we;
  logic       t1_pin;
  logic       count_tick;
  logic [2:0] clock_select;
  logic [9:0] prescale_count;
  logic       timer_running;

  timer_prescaler1 dut (
    .sysClock            (clk),
    .reset               (rst),
    .TCCR1B_input        (tccr1b_in),
    .TCCR1B_write_enable (tccr1b_we),
    .SFIOR_input         (sfior_in),
    .SFIOR_write_enable  (sfior_we),
    .T1_pin              (t1_pin),
    .count_tick          (count_tick),
    .clock_select        (clock_select),
    .prescale_count      (prescale_count),
    .timer_running       (timer_running)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int c0 = 0;

  // Scoreboard: expected cycle numbers at which count_tick is high.
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (count_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL tick_unexpected: count_tick=1 at cycle %0d, required no tick", cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (e !== 32'(cyc))
          $display("FAIL tick_cycle: tick at cycle %0d, required cycle %0d", cyc, e);
        else
          passes++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic t1_level);
    @(negedge clk);
    t1_pin    = t1_level;
    tccr1b_we = 1'b0;
    sfior_we  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c0  = cyc;
  endtask

  task automatic drive_cs(input logic [7:0] v);
    tccr1b_in = v;
    tccr1b_we = 1'b1;
    @(negedge clk);
    tccr1b_we = 1'b0;
  endtask

  task automatic drive_psr10();
    sfior_in = 8'h01;
    sfior_we = 1'b1;
    @(negedge clk);
    sfior_we = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; tccr1b_in = 8'h00; tccr1b_we = 1'b0;
    sfior_in = 8'h00; sfior_we = 1'b0; t1_pin = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (count_tick !== 1'b0) $display("FAIL reset_tick: got %b, required 0", count_tick); else passes++;
    checks++; if (clock_select !== 3'b000) $display("FAIL reset_cs: got %b, required 000", clock_select); else passes++;
    checks++; if (prescale_count !== 10'd0) $display("FAIL reset_prescale: got %0d, required 0", prescale_count); else passes++;
    checks++; if (timer_running !== 1'b0) $display("FAIL reset_running: got %b, required 0", timer_running); else passes++;
  endtask

  task automatic test_div8();
    do_reset(1'b0);
    for (int k = 1; k <= 8; k++) exp_q.push_back(32'(c0 + 8 * k));
    drive_cs(8'hAA);  // upper bits must be ignored, CS = 010
    wait_until(c0 + 20);
    checks++; if (prescale_count !== 10'd20) $display("FAIL div8_prescale: got %0d, required 20", prescale_count); else passes++;
    checks++; if (clock_select !== 3'b010) $display("FAIL div8_cs: got %b, required 010", clock_select); else passes++;
    checks++; if (timer_running !== 1'b1) $display("FAIL div8_running: got %b, required 1", timer_running); else passes++;
    wait_until(c0 + 68);
    checks++; if (exp_q.size() != 0) $display("FAIL div8_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
  endtask

  task automatic test_div1024();
    do_reset(1'b0);
    exp_q.push_back(32'(c0 + 1024));
    exp_q.push_back(32'(c0 + 2048));
    drive_cs(8'h05);
    wait_until(c0 + 1023);
    checks++; if (prescale_count !== 10'd1023) $display("FAIL div1024_pre1: got %0d, required 1023", prescale_count); else passes++;
    wait_until(c0 + 2047);
    checks++; if (prescale_count !== 10'd1023) $display("FAIL div1024_pre2: got %0d, required 1023", prescale_count); else passes++;
    wait_until(c0 + 2100);
    checks++; if (exp_q.size() != 0) $display("FAIL div1024_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
  endtask

  task automatic test_psr10();
    do_reset(1'b0);
    exp_q.push_back(32'(c0 + 105));
    exp_q.push_back(32'(c0 + 233));
    drive_cs(8'h03);
    wait_until(c0 + 40);
    checks++; if (prescale_count !== 10'd40) $display("FAIL psr_pre40: got %0d, required 40", prescale_count); else passes++;
    drive_psr10();
    checks++; if (prescale_count !== 10'd0) $display("FAIL psr_clear1: got %0d, required 0", prescale_count); else passes++;
    wait_until(c0 + 168);
    checks++; if (prescale_count !== 10'd127) $display("FAIL psr_pre127: got %0d, required 127", prescale_count); else passes++;
    drive_psr10();  // terminal value for /64 present: tick must be suppressed
    checks++; if (prescale_count !== 10'd0) $display("FAIL psr_clear2: got %0d, required 0", prescale_count); else passes++;
    wait_until(c0 + 240);
    checks++; if (exp_q.size() != 0) $display("FAIL psr_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
  endtask

  task automatic test_t1_edges();
    do_reset(1'b0);
    for (int p = 0; p < 3; p++) exp_q.push_back(32'(c0 + 5 + 10 * p + 3));
    drive_cs(8'h07);
    for (int p = 0; p < 3; p++) begin
      wait_until(c0 + 5 + 10 * p);
      t1_pin = 1'b1;
      wait_until(c0 + 10 + 10 * p);
      t1_pin = 1'b0;
    end
    wait_until(c0 + 40);
    checks++; if (exp_q.size() != 0) $display("FAIL t1_rise_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
    for (int p = 0; p < 3; p++) exp_q.push_back(32'(c0 + 45 + 5 + 10 * p + 3));
    drive_cs(8'h06);
    checks++; if (clock_select !== 3'b110) $display("FAIL t1_fall_cs: got %b, required 110", clock_select); else passes++;
    for (int p = 0; p < 3; p++) begin
      wait_until(c0 + 45 + 10 * p);
      t1_pin = 1'b1;
      wait_until(c0 + 50 + 10 * p);
      t1_pin = 1'b0;
    end
    wait_until(c0 + 80);
    checks++; if (exp_q.size() != 0) $display("FAIL t1_fall_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
  endtask

  task automatic test_t1_high_at_reset();
    do_reset(1'b1);
    exp_q.push_back(32'(c0 + 28));
    drive_cs(8'h07);
    wait_until(c0 + 20);
    checks++; if (exp_q.size() != 1) $display("FAIL t1_settle: %0d ticks outstanding, required 1", exp_q.size()); else passes++;
    t1_pin = 1'b0;
    wait_until(c0 + 25);
    t1_pin = 1'b1;
    wait_until(c0 + 35);
    checks++; if (exp_q.size() != 0) $display("FAIL t1_settle_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
  endtask

  task automatic test_cs001_stop();
    do_reset(1'b0);
    for (int k = 2; k <= 12; k++) exp_q.push_back(32'(c0 + k));
    checks++; if (timer_running !== 1'b0) $display("FAIL div1_running0: got %b, required 0", timer_running); else passes++;
    drive_cs(8'h01);
    checks++; if (timer_running !== 1'b1) $display("FAIL div1_running1: got %b, required 1", timer_running); else passes++;
    checks++; if (clock_select !== 3'b001) $display("FAIL div1_cs: got %b, required 001", clock_select); else passes++;
    wait_until(c0 + 11);
    // Stop write and PSR10 in the same cycle; both take effect.
    tccr1b_in = 8'h00; tccr1b_we = 1'b1;
    sfior_in  = 8'h01; sfior_we  = 1'b1;
    @(negedge clk);
    tccr1b_we = 1'b0; sfior_we = 1'b0;
    checks++; if (clock_select !== 3'b000) $display("FAIL stop_cs: got %b, required 000", clock_select); else passes++;
    checks++; if (timer_running !== 1'b0) $display("FAIL stop_running: got %b, required 0", timer_running); else passes++;
    checks++; if (prescale_count !== 10'd0) $display("FAIL stop_psr: got %0d, required 0", prescale_count); else passes++;
    checks++; if (count_tick !== 1'b1) $display("FAIL stop_last_tick: got %b, required 1", count_tick); else passes++;
    wait_until(c0 + 20);
    checks++; if (exp_q.size() != 0) $display("FAIL div1_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    for (int k = 2; k <= 5; k++) exp_q.push_back(32'(c0 + k));
    drive_cs(8'h01);
    wait_until(c0 + 5);
    #2 rst = 1'b1;
    #1;
    checks++; if (count_tick !== 1'b0) $display("FAIL async_tick: got %b, required 0", count_tick); else passes++;
    checks++; if (clock_select !== 3'b000) $display("FAIL async_cs: got %b, required 000", clock_select); else passes++;
    checks++; if (prescale_count !== 10'd0) $display("FAIL async_prescale: got %0d, required 0", prescale_count); else passes++;
    checks++; if (timer_running !== 1'b0) $display("FAIL async_running: got %b, required 0", timer_running); else passes++;
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    wait_until(c0 + 10);
    checks++; if (exp_q.size() != 0) $display("FAIL async_missing: %0d ticks outstanding, required 0", exp_q.size()); else passes++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_div8();
    test_div1024();
    test_psr10();
    test_t1_edges();
    test_t1_high_at_reset();
    test_cs001_stop();
    test_async_reset();
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
